// File: rtl/md5_hasher_axil_regs_if.sv
// md5_hasher_axil_regs_if: AXI4-Lite bus between the md5_hasher register block and its master.
interface md5_hasher_axil_regs_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [AW-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/md5_hasher_axil_regs.sv
// md5_hasher_axil_regs: AXI4-Lite register block holding the target hash, control/status and match result.
module md5_hasher_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_VERSION = 32'h0001_0000
) (
  input logic ACLK,
  input logic ARESETN,
  md5_hasher_axil_regs_if.slave s_axi,
  output logic [127:0] target_hash,
  output logic core_start,
  input logic core_busy,
  input logic core_match,
  input logic [31:0] core_match_pos
);
  localparam int LANES = C_S_AXI_DATA_WIDTH / 8;
  logic up;
  logic aw_full;
  logic w_full;
  logic [2:0] aw_idx;
  logic [31:0] w_data;
  logic [3:0] w_strb;
  logic bvalid;
  logic rvalid;
  logic [31:0] rdata;
  logic [31:0] rd_mux;
  logic [3:0][31:0] target;
  logic irq_en;
  logic done;
  logic [31:0] match_pos;
  logic wr_en;
  // up keeps the ready outputs low while reset is held and for the edge it releases on
  assign wr_en = aw_full && w_full;
  assign s_axi.awready = up && !aw_full && !bvalid;
  assign s_axi.wready = up && !w_full && !bvalid;
  assign s_axi.arready = up && !rvalid;
  assign s_axi.bvalid = bvalid;
  assign s_axi.bresp = 2'b00;
  assign s_axi.rvalid = rvalid;
  assign s_axi.rdata = rdata;
  assign s_axi.rresp = 2'b00;
  assign target_hash = target;
  always_comb begin
    rd_mux = '0;
    case (s_axi.araddr[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = target[s_axi.araddr[3:2]];
      3'd4: rd_mux = {30'd0, irq_en, 1'b0};
      3'd5: rd_mux = {30'd0, done, core_busy};
      3'd6: rd_mux = match_pos;
      default: rd_mux = C_VERSION;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      up <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      target <= '0;
      irq_en <= 1'b0;
      done <= 1'b0;
      match_pos <= '0;
      core_start <= 1'b0;
    end else begin
      up <= 1'b1;
      core_start <= 1'b0;
      if (s_axi.awvalid && s_axi.awready) begin
        aw_full <= 1'b1;
        aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (bvalid && s_axi.bready) bvalid <= 1'b0;
      if (wr_en) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
        bvalid <= 1'b1;
        if (!aw_idx[2])
          for (int i = 0; i < LANES; i++)
            if (w_strb[i]) target[aw_idx[1:0]][8*i +: 8] <= w_data[8*i +: 8];
        if (aw_idx == 3'd4 && w_strb[0]) begin
          core_start <= w_data[0];
          irq_en <= w_data[1];
        end
      end
      // a match arriving with a DONE clear wins
      if (core_match) begin
        done <= 1'b1;
        match_pos <= core_match_pos;
      end else if (wr_en && aw_idx == 3'd5 && w_strb[0] && w_data[1]) done <= 1'b0;
      if (s_axi.arvalid && s_axi.arready) begin
        rvalid <= 1'b1;
        rdata <= rd_mux;
      end else if (rvalid && s_axi.rready) rvalid <= 1'b0;
    end
endmodule

// File: tb/tb_md5_hasher_axil_regs.sv
// tb_md5_hasher_axil_regs: directed table plus hand sequences for the md5_hasher register block.
module tb_md5_hasher_axil_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] target_hash;
  logic core_start;
  logic core_busy = 1'b0;
  logic core_match = 1'b0;
  logic [31:0] core_match_pos = '0;
  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  md5_hasher_axil_regs_if bus ();
  md5_hasher_axil_regs dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .s_axi(bus),
    .target_hash(target_hash),
    .core_start(core_start),
    .core_busy(core_busy),
    .core_match(core_match),
    .core_match_pos(core_match_pos)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (core_start) start_cnt++;
  typedef struct {
    logic [4:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp, output logic ok);
    bus.awaddr = a;
    bus.wdata = d;
    bus.wstrb = s;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    for (int n = 0; n < 50 && (bus.awvalid || bus.wvalid); n++) begin
      logic aw_hs;
      logic w_hs;
      aw_hs = bus.awvalid && bus.awready;
      w_hs = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs) bus.wvalid = 1'b0;
    end
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    for (int n = 0; n < 50 && !bus.bvalid; n++) @(negedge clk);
    ok = bus.bvalid;
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask
  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp, output logic ok);
    bus.araddr = a;
    bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    for (int n = 0; n < 50 && bus.arvalid; n++) begin
      logic ar_hs;
      ar_hs = bus.arready;
      @(negedge clk);
      if (ar_hs) bus.arvalid = 1'b0;
    end
    bus.arvalid = 1'b0;
    for (int n = 0; n < 50 && !bus.rvalid; n++) @(negedge clk);
    ok = bus.rvalid;
    d = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask
  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic [1:0] resp;
    logic ok;
    axi_read(a, rd, resp, ok);
    check(name, {ok, resp, rd}, {1'b1, 2'b00, exp});
  endtask
  initial begin
    logic [1:0] resp;
    logic ok;
    logic [31:0] rd;
    int hold;
    vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{5'h00, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vecs[5] = '{5'h00, 32'h0000_00AA, 4'b0001, 32'hFFFF_FFAA};
    vecs[6] = '{5'h05, 32'h0055_0000, 4'b0100, 32'h0055_0002};
    vecs[7] = '{5'h10, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[8] = '{5'h1C, 32'h0000_0000, 4'hF, 32'h0001_0000};
    vecs[9] = '{5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[10] = '{5'h14, 32'h0000_0000, 4'hF, 32'h0000_0000};
    bus.awaddr = '0;
    bus.awprot = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0;
    bus.arprot = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, core_start, bus.rdata}, '0);
    check("reset_target", target_hash, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
    for (int i = 0; i < 11; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
      check($sformatf("v%0d_bresp", i), {ok, resp}, 3'b100);
      axi_read(vecs[i].addr, rd, resp, ok);
      check($sformatf("v%0d_rdata", i), {ok, resp, rd}, {1'b1, 2'b00, vecs[i].exp});
      if (i == 3) check("target_hash", target_hash, 128'h00000004_00000003_00000002_00000001);
    end
    // AW alone, W three cycles later, response held back
    @(negedge clk);
    bus.awaddr = 5'h08;
    bus.awvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("split_aw_slot_full", {bus.awready, bus.wready, bus.bvalid}, 3'b010);
    repeat (2) @(negedge clk);
    check("split_no_early_b", bus.bvalid, 1'b0);
    bus.wdata = 32'hDEAD_BEEF;
    bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int n = 0; n < 50 && !bus.bvalid; n++) @(negedge clk);
    check("split_bvalid", bus.bvalid, 1'b1);
    hold = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.bvalid && !bus.awready && !bus.wready) hold++;
    end
    check("bvalid_hold", hold, 5);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_drop", bus.bvalid, 1'b0);
    read_check("split_data", 5'h08, 32'hDEAD_BEEF);
    // START pulse, issued while the core reports busy
    core_busy = 1'b1;
    start_cnt = 0;
    axi_write(5'h10, 32'h1, 4'hF, resp, ok);
    repeat (3) @(negedge clk);
    check("start_pulse_count", start_cnt, 1);
    read_check("ctrl_reads_0", 5'h10, 32'h0);
    core_match = 1'b1;
    core_match_pos = 32'h1234;
    @(negedge clk);
    core_match = 1'b0;
    read_check("status_done_busy", 5'h14, 32'h3);
    read_check("match_pos", 5'h18, 32'h1234);
    core_busy = 1'b0;
    axi_write(5'h14, 32'h2, 4'hF, resp, ok);
    read_check("done_cleared", 5'h14, 32'h0);
    // DONE clear lands in the same cycle as a new match
    @(negedge clk);
    bus.awaddr = 5'h14;
    bus.wdata = 32'h2;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    core_match = 1'b1;
    core_match_pos = 32'h5678;
    @(negedge clk);
    core_match = 1'b0;
    check("w1c_collide_bvalid", bus.bvalid, 1'b1);
    @(negedge clk);
    bus.bready = 1'b0;
    read_check("match_beats_w1c", 5'h14, 32'h2);
    read_check("match_pos_collide", 5'h18, 32'h5678);
    core_match = 1'b1;
    core_match_pos = 32'h1111;
    @(negedge clk);
    core_match_pos = 32'h9ABC;
    @(negedge clk);
    core_match = 1'b0;
    read_check("match_pos_latest", 5'h18, 32'h9ABC);
    // reset with both responses pending
    @(negedge clk);
    bus.awaddr = 5'h08;
    bus.wdata = 32'h11;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    bus.araddr = 5'h00;
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_pending", {bus.bvalid, bus.rvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_drop", {bus.bvalid, bus.rvalid, bus.awready, bus.arready, bus.rdata}, '0);
    check("async_reset_target", target_hash, '0);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.bvalid || bus.rvalid) hold++;
    end
    check("no_resp_after_reset", hold, 0);
    for (int i = 0; i < 8; i++) begin
      logic [4:0] a;
      a = 5'(i * 4);
      read_check($sformatf("post_reset_%0d", i), a, i == 7 ? 32'h0001_0000 : 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
